// File: rtl/rv_slave_fifo.sv
// Ready/valid byte sink: FWFT FIFO, sticky master protocol checker, optional stats (RV_SLAVE_STATS_EN).
// Latency: a byte accepted at edge N is on o_data/o_valid after edge N; 1-cycle sink-to-output.
// Backpressure: s_ready is registered from next-count < DEPTH; no combinational path from o_ready to s_ready.
module rv_slave_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          aclk,
    input  logic          rstn,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [AW:0]   fill,
    output logic          proto_err,
    output logic [15:0]   xfer_cnt,
    output logic [15:0]   data_sum
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          s_ready_q, s_ready_d;
    logic          stall_q, stall_d;
    logic [DW-1:0] stall_data_q, stall_data_d;
    logic          proto_err_q, proto_err_d;
    logic          wr, rd;

    // Handshakes, FIFO bookkeeping and the registered ready for the master
    always_comb begin
        wr       = s_valid && s_ready_q;
        rd       = (count_q != '0) && o_ready;
        mem_d    = mem_q;
        if (wr) begin
            mem_d[wr_ptr_q] = s_data;
        end
        wr_ptr_d  = wr_ptr_q + AW'(wr);
        rd_ptr_d  = rd_ptr_q + AW'(rd);
        count_d   = count_q + (AW+1)'(wr) - (AW+1)'(rd);
        s_ready_d = (count_d < (AW+1)'(DEPTH));
    end

    // Protocol checker: a stalled beat must stay valid with unchanged data
    always_comb begin
        stall_d      = s_valid && !s_ready_q;
        stall_data_d = s_data;
        proto_err_d  = proto_err_q;
        if (stall_q && (!s_valid || (s_data != stall_data_q))) begin
            proto_err_d = 1'b1;
        end
    end

    // Storage array carries no reset; its contents are meaningless until written
    always_ff @(posedge aclk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!rstn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            s_ready_q    <= 1'b0;
            stall_q      <= 1'b0;
            stall_data_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            s_ready_q    <= s_ready_d;
            stall_q      <= stall_d;
            stall_data_q <= stall_data_d;
            proto_err_q  <= proto_err_d;
        end
    end

`ifdef RV_SLAVE_STATS_EN
    logic [15:0] xfer_cnt_q, xfer_cnt_d;
    logic [15:0] data_sum_q, data_sum_d;

    // Accepted-beat count and payload sum, both wrapping modulo 2^16
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        data_sum_d = data_sum_q;
        if (wr) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
            data_sum_d = data_sum_q + 16'(s_data);
        end
    end

    // Stats registers
    always_ff @(posedge aclk) begin
        if (!rstn) begin
            xfer_cnt_q <= '0;
            data_sum_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
            data_sum_q <= data_sum_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
    assign data_sum = data_sum_q;
`else
    assign xfer_cnt = 16'd0;
    assign data_sum = 16'd0;
`endif

    assign s_ready   = s_ready_q;
    assign o_valid   = (count_q != '0);
    assign o_data    = mem_q[rd_ptr_q];
    assign fill      = count_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_rv_slave_fifo.sv
// Bench for rv_slave_fifo: directed scenarios then random traffic against a queue-based reference.
// Latency: outputs sampled on the falling edge, inputs driven 1 time unit after the rising edge.
// Backpressure: the bench master follows the reference model's ready, not the DUT's.
module tb_rv_slave_fifo;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic          aclk = 1'b0;
    logic          rstn;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_ready;
    logic [AW:0]   fill;
    logic          proto_err;
    logic [15:0]   xfer_cnt;
    logic [15:0]   data_sum;

    rv_slave_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .rstn(rstn),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
        .fill(fill), .proto_err(proto_err),
        .xfer_cnt(xfer_cnt), .data_sum(data_sum)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ready = 0;
    bit         m_err   = 0;
    bit         m_stall = 0;
    logic [7:0] m_sdat  = 0;
    int         m_xfer  = 0;
    int         m_sum   = 0;

    // Values seen at the last falling-edge sample
    logic [7:0]  last_odata;
    logic [AW:0] last_fill;
    logic        last_perr;
    logic [15:0] last_xfer;
    logic [15:0] last_sum;

`ifdef RV_SLAVE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs against the model, then advance the model at the edge
    task automatic step();
        bit acc;
        @(negedge aclk);
        last_odata = o_data;
        last_fill  = fill;
        last_perr  = proto_err;
        last_xfer  = xfer_cnt;
        last_sum   = data_sum;
        chk("fill", 32'(fill), 32'(q.size()));
        chk("o_valid", 32'(o_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("o_data", 32'(o_data), 32'(q[0]));
        chk("s_ready", 32'(s_ready), 32'(m_ready));
        chk("proto_err", 32'(proto_err), 32'(m_err));
        chk("xfer_cnt", 32'(xfer_cnt), STATS ? 32'(m_xfer) : 32'd0);
        chk("data_sum", 32'(data_sum), STATS ? 32'(m_sum) : 32'd0);
        @(posedge aclk);
        if (!rstn) begin
            q.delete();
            m_ready = 0; m_err = 0; m_stall = 0; m_xfer = 0; m_sum = 0;
        end else begin
            acc = s_valid && m_ready;
            if (m_stall && (!s_valid || s_data != m_sdat)) m_err = 1;
            m_stall = s_valid && !m_ready;
            m_sdat  = s_data;
            if (q.size() != 0 && o_ready) void'(q.pop_front());
            if (acc) begin
                q.push_back(s_data);
                m_xfer = (m_xfer + 1) % 65536;
                m_sum  = (m_sum + int'(s_data)) % 65536;
            end
            m_ready = (q.size() < DEPTH);
        end
        #1;
    endtask

    // Present one byte and hold it until the model says it was taken
    task automatic send(input logic [7:0] d);
        bit done = 0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            done = m_ready;
            step();
        end
        s_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: byte %0h not accepted within 50 cycles", d);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        logic [7:0] order [4];
        int         n;
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; o_ready = 1'b0;
        @(posedge aclk);
        #1;

        // Reset state, then a single byte straight through
        do_reset();
        chk("rst_fill", 32'(last_fill), 32'd0);
        o_ready = 1'b1;
        send(8'h05);
        step();
        chk("single_out", 32'(last_odata), 32'h05);
        step();
        chk("single_drained", 32'(last_fill), 32'd0);

        // Fill to DEPTH, stall a fifth byte, one read frees space
        o_ready = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        s_valid = 1'b1; s_data = 8'h09;
        step();
        chk("full_fill", 32'(last_fill), 32'd4);
        step();
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
        step();
        s_valid = 1'b0;
        order[0] = 8'h02; order[1] = 8'h03; order[2] = 8'h04; order[3] = 8'h09;
        o_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_order", 32'(last_odata), 32'(order[i]));
        end
        step();

        // Steady stream at fill=2: pointers wrap twice
        o_ready = 1'b0;
        send(8'h30); send(8'h31);
        o_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_data = 8'($urandom);
            step();
            chk("stream_fill", 32'(last_fill), 32'd2);
        end
        s_valid = 1'b0;
        repeat (3) step();

        // Protocol violation: valid dropped while stalled
        o_ready = 1'b0;
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        s_valid = 1'b1; s_data = 8'h07;
        step();
        s_valid = 1'b0;
        step();
        step();
        chk("perr_drop", 32'(last_perr), 32'd1);
        o_ready = 1'b1;
        send(8'h21); send(8'h22);
        repeat (6) step();
        chk("perr_sticky", 32'(last_perr), 32'd1);
        do_reset();
        chk("perr_cleared", 32'(last_perr), 32'd0);

        // Protocol violation: data changed while stalled
        o_ready = 1'b0;
        send(8'h41); send(8'h42); send(8'h43); send(8'h44);
        s_valid = 1'b1; s_data = 8'h07;
        step();
        s_data = 8'h08;
        step();
        s_valid = 1'b0;
        step();
        chk("perr_data", 32'(last_perr), 32'd1);

        // Reset with entries buffered discards them
        do_reset();
        o_ready = 1'b0;
        send(8'h51); send(8'h52); send(8'h53);
        step();
        chk("pre_rst_fill", 32'(last_fill), 32'd3);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        chk("post_rst_fill", 32'(last_fill), 32'd0);
        send(8'h0A);
        step();
        chk("first_after_rst", 32'(last_odata), 32'h0A);

        // 300 accepted bytes of 0x0F for the stats counters
        do_reset();
        o_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h0F;
        n = 0;
        for (int i = 0; i < 400 && n < 300; i++) begin
            if (m_ready) n++;
            step();
        end
        s_valid = 1'b0;
        step();
        chk("xfer_300", 32'(last_xfer), STATS ? 32'd300 : 32'd0);
        chk("sum_300", 32'(last_sum), STATS ? 32'd4500 : 32'd0);

        // Random traffic, mostly protocol-legal, with rare resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            o_ready = ($urandom_range(0, 3) != 0);
            if (!(s_valid && !m_ready) || $urandom_range(0, 63) == 0) begin
                s_valid = ($urandom_range(0, 2) != 0);
                s_data  = 8'($urandom);
            end
            rstn = ($urandom_range(0, 299) != 0);
            step();
        end
        rstn = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_slave_fifo.md
Name: rv_slave_fifo

Overview:
- Downstream consumer for the 8-bit ready/valid data master.
- Drives the master's ready input.
- Buffers accepted bytes in a small first-word-fall-through FIFO and presents them on an output ready/valid port for the next stage.
- Includes a sticky protocol checker that flags master handshake-rule violations.

Parameters:
- DW, 8: data width of input and output payload.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- AW, $clog2(DEPTH): pointer width (derived; do not override).

Ports:
- aclk  input  1  clock; all state updates on rising edge.
- rstn  input  1  synchronous active-low reset, sampled on aclk.
- s_data  input  DW  payload from master (master m_data).
- s_valid  input  1  master valid (master m_valid).
- s_ready  output  1  ready to master; registered.
- o_data  output  DW  head-of-FIFO payload to next stage.
- o_valid  output  1  head entry present.
- o_ready  input  1  next stage accepts o_data.
- fill  output  AW+1  current entry count, 0..DEPTH.
- proto_err  output  1  sticky master protocol violation flag.
- xfer_cnt  output  16  accepted-transfer count (see Optional Feature).
- data_sum  output  16  running payload sum (see Optional Feature).

Behaviour:
- Reset (rstn=0 at posedge):
  - wr_ptr=0, rd_ptr=0, count=0, so fill=0 and o_valid=0.
  - s_ready=0, proto_err=0, xfer_cnt=0, data_sum=0.
  - FIFO contents are don't-care.
  - Reset mid-transfer discards all buffered data; no handshake completes in a reset cycle.
- Write: occurs at the posedge where s_valid&&s_ready. Stores s_data at wr_ptr; wr_ptr increments and wraps DEPTH-1 -> 0.
- Read: occurs at the posedge where o_valid&&o_ready. rd_ptr increments with the same wrap.
- count_next = count + wr - rd. Simultaneous write and read leaves count unchanged.
- s_ready register: next value = (count_next < DEPTH). It is 1 the first cycle after reset release and 0 in the cycle after the FIFO becomes full.
  - Never write while full.
  - No combinational path from o_ready to s_ready.
- o_valid = (count != 0); o_data = mem[rd_ptr] (FWFT).
- Latency: a byte written at edge N is visible on o_data/o_valid after edge N, i.e. readable at edge N+1.
- Empty: o_valid=0 and o_data holds a stale value; o_ready is ignored.
- Full: s_ready=0. A read at edge N reasserts s_ready after edge N, so the first new write is possible at edge N+1.
- Protocol checker: a stall cycle is one sampled with s_valid=1 and s_ready=0. If the next cycle sees s_valid=0, or s_data differs from the stalled value, set proto_err=1 at that edge. It stays set until reset. The checker is inactive during reset.
- Arithmetic: pointer and count wrap are modulo the pointer width. fill never exceeds DEPTH.

Optional Feature:
- Macro RV_SLAVE_STATS_EN.
- Defined:
  - xfer_cnt increments by 1 on each accepted write, wrapping 0xFFFF -> 0.
  - data_sum adds the zero-extended s_data on each accepted write, modulo 2^16.
  - Both update at the same edge as the write and reset to 0.
- Undefined: no counter logic is built; xfer_cnt and data_sum are tied to 0. The port list is unchanged.

Test Plan:
- Reset, then master sends 0x05 with o_ready=1 -> s_ready=1 one cycle after rstn release; write at edge N; o_valid=1/o_data=0x05 after N; read at N+1; fill returns to 0; proto_err=0.
- o_ready=0, master sends 0x01,0x02,0x03,0x04 (DEPTH=4) -> fill=4, s_ready=0; 5th byte 0x09 stalls with valid held. Raise o_ready for one cycle -> 0x01 read, s_ready=1 next cycle, 0x09 accepted. Output order is 0x02,0x03,0x04,0x09.
- Continuous stream, o_ready=1 and fill=2 -> simultaneous read/write holds fill=2 for 8 consecutive edges. Pointers wrap twice with no loss or duplication.
- With the FIFO full and s_valid=1, s_data=0x07: drop s_valid next cycle -> proto_err=1 and stays 1 across later good transfers. Separate run changing s_data to 0x08 while stalled -> proto_err=1. Assert rstn=0 -> proto_err=0.
- Reset asserted with fill=3 -> after the reset edge fill=0, o_valid=0, s_ready=0. After release s_ready=1 and the next byte 0x0A is the first output.
- With RV_SLAVE_STATS_EN, accept 0x0F x 300 -> xfer_cnt=300, data_sum=4500 (0x1194). Without the macro both read 0 throughout.
